player_move_ctrl: RTL and testbench
===================================

# player_move_ctrl

Frame-tick-driven movement controller for the player sprite. It synchronizes and debounces the left/right buttons, runs a direction state machine with speed ramp-up, and owns the registered player X position, clamped to the playfield. It sits between the board buttons and the sprite renderer/collision logic, and it replaces the purely combinational position update with a sequenced one.

## Interface
- SCREEN_W, 240, playfield width in pixels
- PLAYER_W, 24, sprite width; right bound = SCREEN_W - PLAYER_W (216)
- START_POS, 108, position after reset or respawn
- MAX_SPEED, 4, speed ceiling in px/tick (1..7)
- ACCEL_FRAMES, 8, ticks held at one speed before incrementing (≥1)
- DEBOUNCE_FRAMES, 2, consecutive ticks a button must read high (1..7)

- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous, active-high reset
- i_fTick  in  1  one-clock frame strobe; all movement happens only on these cycles
- i_Btn_Left  in  1  raw left button, asynchronous
- i_Btn_Right  in  1  raw right button, asynchronous
- i_Enable  in  1  game running; low freezes movement
- i_Respawn  in  1  synchronous one-clock request to recentre the player
- o_Player_Position  out  10  registered sprite X, range 0..216
- o_Speed  out  3  current speed (0 when not moving)
- o_Dir  out  2  00 idle, 01 left, 10 right, 11 both pressed (hold)
- o_At_Left  out  1  o_Player_Position == 0
- o_At_Right  out  1  o_Player_Position == SCREEN_W-PLAYER_W

## Operation
- Synchronizer: each button passes through a 2-flop synchronizer on every clock, regardless of i_fTick.
- Debounce, per button, on i_fTick only: if the synced level is high, cnt = min(cnt+1, DEBOUNCE_FRAMES); otherwise cnt = 0. A button is pressed on this tick when the new cnt == DEBOUNCE_FRAMES.
- States: IDLE, MOVE_L, MOVE_R, HOLD. Transitions happen on i_fTick only, using this tick's pressed flags (L, R):
  - L&R → HOLD; L only → MOVE_L; R only → MOVE_R; neither → IDLE.
- Entering MOVE_x from any other state (including reversal):
  - speed = 1;
  - move 1 px on that same tick;
  - hold_cnt = 1.
- Staying in MOVE_x:
  - move by the current speed;
  - hold_cnt += 1;
  - when hold_cnt reaches ACCEL_FRAMES: hold_cnt = 0 and speed = min(speed+1, MAX_SPEED).
- Arithmetic: computed in 11 bits.
  - Left: pos = (pos < speed) ? 0 : pos - speed.
  - Right: pos = (pos + speed > 216) ? 216 : pos + speed.
  - If the result was clamped, speed = 1 and hold_cnt = 0 (wall stop); the state stays MOVE_x.
- IDLE/HOLD: position held, speed = 0, hold_cnt = 0.
- i_Enable low:
  - state forced to IDLE, speed 0, position held;
  - debounce counters still update;
  - on re-enable, motion restarts at speed 1.
- i_Respawn:
  - highest synchronous priority, acts on any clock;
  - pos = START_POS, state IDLE, speed 0, hold_cnt 0, debounce counters 0.
- Reset: pos = START_POS, state IDLE, o_Speed 0, o_Dir 00, all counters and sync flops 0. o_At_Left and o_At_Right are derived from the registered position, so both are 0 at START_POS.

## Timing
- Button to synced value: 2 clocks. Synced-high to first move: DEBOUNCE_FRAMES ticks. The move happens on the tick where cnt reaches the threshold.
- All outputs are registered and change on the clock edge ending the i_fTick cycle, or the i_Respawn cycle. They are stable between ticks.
- i_Respawn coinciding with i_fTick: respawn wins; no move is applied.
- i_fTick asserted on consecutive clocks is legal; each assertion is a full tick.
- Asynchronous reset mid-frame: all state returns to reset values immediately. The first move needs a fresh debounce.

## Test plan
- Reset, hold Right, DEBOUNCE_FRAMES=2, 20 ticks:
  - first move on tick 2;
  - positions 109..116 at speed 1 over 8 ticks, then speed 2;
  - o_Dir=10.
- Hold Left from START_POS for 60 ticks:
  - speed ramps 1→4 and saturates;
  - position clamps at 0, o_At_Left=1, o_Speed drops to 1, never wraps below 0.
- Hold Right from pos 214 at speed 4:
  - next tick gives 216 (not 218), o_At_Right=1.
- Moving right at speed 3, switch to Left:
  - debounce interval: Left not yet pressed, state IDLE, speed 0;
  - then MOVE_L, first step 1 px, o_Dir=01.
- Press both buttons: o_Dir=11, position constant, o_Speed=0. Release Right: moves left at speed 1.
- Mid-move i_Respawn coincident with i_fTick: next clock pos=108, o_Speed=0. Then drop i_Enable with Right held: no motion. Assert i_Rst asynchronously: outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/player_move_ctrl_if.sv
// Bus between the board/game logic and the player movement controller.
// The master drives the frame strobe, buttons and game-control requests.
// The slave (the controller) returns the sprite position and motion status.
interface player_move_ctrl_if;
    logic       i_fTick;
    logic       i_Btn_Left;
    logic       i_Btn_Right;
    logic       i_Enable;
    logic       i_Respawn;
    logic [9:0] o_Player_Position;
    logic [2:0] o_Speed;
    logic [1:0] o_Dir;
    logic       o_At_Left;
    logic       o_At_Right;

    modport master (
        output i_fTick, i_Btn_Left, i_Btn_Right, i_Enable, i_Respawn,
        input  o_Player_Position, o_Speed, o_Dir, o_At_Left, o_At_Right
    );

    modport slave (
        input  i_fTick, i_Btn_Left, i_Btn_Right, i_Enable, i_Respawn,
        output o_Player_Position, o_Speed, o_Dir, o_At_Left, o_At_Right
    );
endinterface

// File: rtl/player_move_ctrl.sv
// Player sprite movement controller.
// Synchronizes and debounces the left/right buttons, runs the direction
// state machine with speed ramp-up and keeps the clamped player X position.
// Everything except the button synchronizers advances only on frame ticks.
module player_move_ctrl #(
    parameter int SCREEN_W        = 240,
    parameter int PLAYER_W        = 24,
    parameter int START_POS       = 108,
    parameter int MAX_SPEED       = 4,
    parameter int ACCEL_FRAMES    = 8,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    player_move_ctrl_if.slave  bus
);

    localparam logic [9:0] RIGHT_BOUND = 10'(SCREEN_W - PLAYER_W);
    localparam logic [9:0] START_P     = 10'(START_POS);
    localparam logic [2:0] SPEED_MAX   = 3'(MAX_SPEED);
    localparam logic [2:0] DB_MAX      = 3'(DEBOUNCE_FRAMES);
    // Hold counter is wide enough to step one past ACCEL_FRAMES without wrapping.
    localparam int         HOLD_W      = $clog2(ACCEL_FRAMES + 2);
    localparam logic [HOLD_W-1:0] ACCEL_MAX = HOLD_W'(ACCEL_FRAMES);

    // Encoding doubles as the o_Dir value: 00 idle, 01 left, 10 right, 11 both.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MOVE_L = 2'b01,
        ST_MOVE_R = 2'b10,
        ST_HOLD   = 2'b11
    } state_t;

    logic [1:0]        r_SyncL;
    logic [1:0]        r_SyncR;
    logic [2:0]        r_CntL;
    logic [2:0]        r_CntR;
    state_t            r_State;
    logic [9:0]        r_Pos;
    logic [2:0]        r_Speed;
    logic [HOLD_W-1:0] r_Hold;

    logic [2:0]        w_CntL;
    logic [2:0]        w_CntR;
    logic              w_PressL;
    logic              w_PressR;
    state_t            w_Dir;
    state_t            w_NextState;
    logic [9:0]        w_NextPos;
    logic [2:0]        w_NextSpeed;
    logic [HOLD_W-1:0] w_NextHold;
    logic [HOLD_W-1:0] w_HoldInc;
    logic [2:0]        w_NextCntL;
    logic [2:0]        w_NextCntR;
    logic [10:0]       w_Step;
    logic [10:0]       w_Target;
    logic              w_Clamped;
    logic              w_Entering;

    // Debounce counters saturate at the threshold while the synced level is high.
    always_comb begin
        w_CntL = 3'd0;
        w_CntR = 3'd0;
        if (r_SyncL[1]) begin
            w_CntL = (r_CntL >= DB_MAX) ? DB_MAX : r_CntL + 3'd1;
        end
        if (r_SyncR[1]) begin
            w_CntR = (r_CntR >= DB_MAX) ? DB_MAX : r_CntR + 3'd1;
        end
        w_PressL = (w_CntL == DB_MAX);
        w_PressR = (w_CntR == DB_MAX);
    end

    // Next-state, speed ramp and clamped position arithmetic for this cycle.
    always_comb begin
        w_NextState = r_State;
        w_NextPos   = r_Pos;
        w_NextSpeed = r_Speed;
        w_NextHold  = r_Hold;
        w_NextCntL  = r_CntL;
        w_NextCntR  = r_CntR;
        w_Dir       = ST_IDLE;
        w_HoldInc   = r_Hold + HOLD_W'(1);
        w_Step      = 11'd0;
        w_Target    = 11'd0;
        w_Clamped   = 1'b0;
        w_Entering  = 1'b0;

        if (bus.i_Respawn) begin
            w_NextState = ST_IDLE;
            w_NextPos   = START_P;
            w_NextSpeed = 3'd0;
            w_NextHold  = '0;
            w_NextCntL  = 3'd0;
            w_NextCntR  = 3'd0;
        end else if (bus.i_fTick) begin
            w_NextCntL = w_CntL;
            w_NextCntR = w_CntR;
            if (!bus.i_Enable) begin
                w_NextState = ST_IDLE;
                w_NextSpeed = 3'd0;
                w_NextHold  = '0;
            end else begin
                case ({w_PressR, w_PressL})
                    2'b11:   w_Dir = ST_HOLD;
                    2'b01:   w_Dir = ST_MOVE_L;
                    2'b10:   w_Dir = ST_MOVE_R;
                    default: w_Dir = ST_IDLE;
                endcase
                w_NextState = w_Dir;

                if (w_Dir == ST_MOVE_L || w_Dir == ST_MOVE_R) begin
                    // A fresh or reversed move always starts with a single pixel step.
                    w_Entering = (r_State != w_Dir);
                    if (w_Entering) begin
                        w_Step      = 11'd1;
                        w_NextSpeed = 3'd1;
                        w_NextHold  = HOLD_W'(1);
                    end else begin
                        w_Step = {8'd0, r_Speed};
                        if (w_HoldInc >= ACCEL_MAX) begin
                            w_NextHold  = '0;
                            w_NextSpeed = (r_Speed >= SPEED_MAX) ? SPEED_MAX : r_Speed + 3'd1;
                        end else begin
                            w_NextHold = w_HoldInc;
                        end
                    end

                    if (w_Dir == ST_MOVE_L) begin
                        if ({1'b0, r_Pos} < w_Step) begin
                            w_Target  = 11'd0;
                            w_Clamped = 1'b1;
                        end else begin
                            w_Target = {1'b0, r_Pos} - w_Step;
                        end
                    end else begin
                        w_Target = {1'b0, r_Pos} + w_Step;
                        if (w_Target > {1'b0, RIGHT_BOUND}) begin
                            w_Target  = {1'b0, RIGHT_BOUND};
                            w_Clamped = 1'b1;
                        end
                    end
                    w_NextPos = w_Target[9:0];

                    // Hitting a wall drops back to the slowest speed but keeps direction.
                    if (w_Clamped) begin
                        w_NextSpeed = 3'd1;
                        w_NextHold  = '0;
                    end
                end else begin
                    w_NextSpeed = 3'd0;
                    w_NextHold  = '0;
                end
            end
        end
    end

    // Button synchronizers run every clock; movement state loads the computed next values.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_SyncL <= 2'b00;
            r_SyncR <= 2'b00;
            r_CntL  <= 3'd0;
            r_CntR  <= 3'd0;
            r_State <= ST_IDLE;
            r_Pos   <= START_P;
            r_Speed <= 3'd0;
            r_Hold  <= '0;
        end else begin
            r_SyncL <= {r_SyncL[0], bus.i_Btn_Left};
            r_SyncR <= {r_SyncR[0], bus.i_Btn_Right};
            r_CntL  <= w_NextCntL;
            r_CntR  <= w_NextCntR;
            r_State <= w_NextState;
            r_Pos   <= w_NextPos;
            r_Speed <= w_NextSpeed;
            r_Hold  <= w_NextHold;
        end
    end

    assign bus.o_Player_Position = r_Pos;
    assign bus.o_Speed           = r_Speed;
    assign bus.o_Dir             = r_State;
    assign bus.o_At_Left         = (r_Pos == 10'd0);
    assign bus.o_At_Right        = (r_Pos == RIGHT_BOUND);

endmodule

// File: tb/tb_player_move_ctrl.sv
// Self-checking bench for player_move_ctrl: directed scenarios followed by
// randomized button/tick/enable/respawn activity, compared every clock
// against a behavioural model of the movement rules.
module tb_player_move_ctrl;

    localparam int RB    = 216;
    localparam int START = 108;
    localparam int MAXSP = 4;
    localparam int ACCEL = 8;
    localparam int DB    = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Model state
    int mPos, mSpeed, mHold, mDir, mCntL, mCntR;
    int qL[$];
    int qR[$];

    player_move_ctrl_if bus ();

    player_move_ctrl dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("pos",     32'(bus.o_Player_Position), mPos);
        checkOutput("speed",   32'(bus.o_Speed),           mSpeed);
        checkOutput("dir",     32'(bus.o_Dir),             mDir);
        checkOutput("atLeft",  32'(bus.o_At_Left),         (mPos == 0)  ? 1 : 0);
        checkOutput("atRight", 32'(bus.o_At_Right),        (mPos == RB) ? 1 : 0);
    endtask

    task automatic modelReset();
        mPos = START; mSpeed = 0; mHold = 0; mDir = 0; mCntL = 0; mCntR = 0;
        qL = {0, 0};
        qR = {0, 0};
    endtask

    // One clock edge of the movement rules; button levels reach debounce two clocks late.
    task automatic modelStep(input bit tick, input bit l, input bit r, input bit en, input bit resp);
        int sl, sr, newDir, step, target;
        sl = qL.pop_front();
        sr = qR.pop_front();
        qL.push_back(l ? 1 : 0);
        qR.push_back(r ? 1 : 0);
        if (resp) begin
            mPos = START; mSpeed = 0; mHold = 0; mDir = 0; mCntL = 0; mCntR = 0;
        end else if (tick) begin
            mCntL = (sl != 0) ? ((mCntL + 1 > DB) ? DB : mCntL + 1) : 0;
            mCntR = (sr != 0) ? ((mCntR + 1 > DB) ? DB : mCntR + 1) : 0;
            if (!en) begin
                mDir = 0; mSpeed = 0; mHold = 0;
            end else begin
                newDir = ((mCntL == DB) ? 1 : 0) + ((mCntR == DB) ? 2 : 0);
                if (newDir == 1 || newDir == 2) begin
                    if (newDir != mDir) begin
                        step = 1; mSpeed = 1; mHold = 1;
                    end else begin
                        step = mSpeed;
                        mHold++;
                        if (mHold >= ACCEL) begin
                            mHold  = 0;
                            mSpeed = (mSpeed + 1 > MAXSP) ? MAXSP : mSpeed + 1;
                        end
                    end
                    target = (newDir == 1) ? mPos - step : mPos + step;
                    if (target < 0) begin
                        mPos = 0; mSpeed = 1; mHold = 0;
                    end else if (target > RB) begin
                        mPos = RB; mSpeed = 1; mHold = 0;
                    end else begin
                        mPos = target;
                    end
                end else begin
                    mSpeed = 0; mHold = 0;
                end
                mDir = newDir;
            end
        end
    endtask

    // Drive one clock's worth of inputs, then check the outputs just after the edge.
    task automatic applyStimulus(input bit tick, input bit l, input bit r, input bit en, input bit resp);
        bus.i_fTick     = tick;
        bus.i_Btn_Left  = l;
        bus.i_Btn_Right = r;
        bus.i_Enable    = en;
        bus.i_Respawn   = resp;
        @(posedge clk);
        #1;
        modelStep(tick, l, r, en, resp);
        checkAll();
    endtask

    task automatic runTicks(input int n, input bit l, input bit r, input bit en, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, l, r, en, 1'b0);
            applyStimulus(1'b1, l, r, en, 1'b0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.i_fTick = 1'b0; bus.i_Btn_Left = 1'b0; bus.i_Btn_Right = 1'b0;
        bus.i_Enable = 1'b1; bus.i_Respawn = 1'b0;
        rst = 1'b1;
        modelReset();
        #1;
        checkAll();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkAll();

        // Hold Right: first move on tick 2, 109..116 at speed 1, then speed 2.
        runTicks(1, 1'b0, 1'b1, 1'b1, 2);
        checkOutput("tick1Pos", 32'(bus.o_Player_Position), 108);
        runTicks(1, 1'b0, 1'b1, 1'b1, 2);
        checkOutput("firstMove", 32'(bus.o_Player_Position), 109);
        checkOutput("firstDir", 32'(bus.o_Dir), 2);
        runTicks(7, 1'b0, 1'b1, 1'b1, 2);
        checkOutput("pos116", 32'(bus.o_Player_Position), 116);
        checkOutput("speed2", 32'(bus.o_Speed), 2);
        runTicks(1, 1'b0, 1'b1, 1'b1, 2);
        checkOutput("pos118", 32'(bus.o_Player_Position), 118);
        runTicks(10, 1'b0, 1'b1, 1'b1, 2);

        // Hold Left with back-to-back ticks until the left wall.
        runTicks(60, 1'b1, 1'b0, 1'b1, 0);
        checkOutput("leftWall", 32'(bus.o_Player_Position), 0);
        checkOutput("leftFlag", 32'(bus.o_At_Left), 1);
        checkOutput("leftSpeed", 32'(bus.o_Speed), 1);

        // Hold Right all the way to the right wall.
        runTicks(70, 1'b0, 1'b1, 1'b1, 1);
        checkOutput("rightWall", 32'(bus.o_Player_Position), RB);
        checkOutput("rightFlag", 32'(bus.o_At_Right), 1);

        // Reversal: respawn, build up speed 3 going right, then switch to Left.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        runTicks(20, 1'b0, 1'b1, 1'b1, 2);
        checkOutput("speed3", 32'(bus.o_Speed), 3);
        runTicks(1, 1'b1, 1'b0, 1'b1, 2);
        checkOutput("revIdleDir", 32'(bus.o_Dir), 0);
        checkOutput("revIdleSpd", 32'(bus.o_Speed), 0);
        runTicks(1, 1'b1, 1'b0, 1'b1, 2);
        checkOutput("revDir", 32'(bus.o_Dir), 1);
        checkOutput("revSpeed", 32'(bus.o_Speed), 1);

        // Both pressed holds still; releasing Right moves left at speed 1.
        runTicks(4, 1'b1, 1'b1, 1'b1, 2);
        checkOutput("bothDir", 32'(bus.o_Dir), 3);
        checkOutput("bothSpeed", 32'(bus.o_Speed), 0);
        runTicks(1, 1'b1, 1'b0, 1'b1, 2);
        checkOutput("relDir", 32'(bus.o_Dir), 1);
        checkOutput("relSpeed", 32'(bus.o_Speed), 1);

        // Respawn coincident with a tick, then disabled game with Right held.
        runTicks(5, 1'b0, 1'b1, 1'b1, 2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("respPos", 32'(bus.o_Player_Position), START);
        checkOutput("respSpeed", 32'(bus.o_Speed), 0);
        runTicks(10, 1'b0, 1'b1, 1'b0, 2);
        checkOutput("disabledPos", 32'(bus.o_Player_Position), START);
        runTicks(6, 1'b0, 1'b1, 1'b1, 2);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        runTicks(4, 1'b0, 1'b1, 1'b1, 2);

        // Randomized activity.
        begin
            bit l, r, en;
            l = 1'b0; r = 1'b0; en = 1'b1;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 15) == 0) l  = ~l;
                if ($urandom_range(0, 15) == 0) r  = ~r;
                if ($urandom_range(0, 63) == 0) en = ~en;
                applyStimulus(($urandom_range(0, 2) == 0), l, r, en, ($urandom_range(0, 199) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
